// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC-sequential requests to instruction memory, a DEPTH-entry
// instruction queue toward decode, and redirect with flush and discard of stale responses.
module fetch_unit #(
  parameter int              XLEN     = 32,
  parameter int              ILEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              PC_STEP  = 4,
  parameter int              DEPTH    = 4
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req_valid,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_req_ready,
  input  logic            imem_rsp_valid,
  input  logic [ILEN-1:0] imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [ILEN-1:0] out_instr,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_pc_next,
  output logic [XLEN-1:0] fetch_pc,
  output logic            protocol_err
);

  localparam int              AW   = $clog2(DEPTH);
  localparam int              CW   = AW + 1;
  localparam logic [XLEN-1:0] STEP = XLEN'(PC_STEP);

  logic [ILEN-1:0] q_mem [DEPTH];
  logic [AW-1:0]   rd_ptr, wr_ptr;
  logic [CW-1:0]   q_count, inflight, drop_cnt;
  logic [XLEN-1:0] head_pc;
  logic [CW+1:0]   used;
  logic            credit, issue, pop, push, rsp_drop, rsp_live, rsp_err;

  // Every slot is either queued, awaiting a live response, or awaiting a response to discard.
  always_comb begin
    used     = (CW+2)'(q_count) + (CW+2)'(inflight) + (CW+2)'(drop_cnt);
    credit   = used < (CW+2)'(DEPTH);
    rsp_drop = imem_rsp_valid && (drop_cnt != '0);
    rsp_live = imem_rsp_valid && (drop_cnt == '0) && (inflight != '0);
    rsp_err  = imem_rsp_valid && (drop_cnt == '0) && (inflight == '0);
    imem_req_valid = credit && !redirect_valid && !reset;
    issue     = imem_req_valid && imem_req_ready;
    out_valid = (q_count != '0) && !redirect_valid;
    pop       = out_valid && out_ready;
    push      = rsp_live && !redirect_valid;
    out_instr = (q_count != '0) ? q_mem[rd_ptr] : '0;
  end

  assign imem_req_addr = fetch_pc;
  assign out_pc        = head_pc;
  assign out_pc_next   = head_pc + STEP;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc     <= RESET_PC;
      head_pc      <= RESET_PC;
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      q_count      <= '0;
      inflight     <= '0;
      drop_cnt     <= '0;
      protocol_err <= 1'b0;
    end else if (redirect_valid) begin
      // Outstanding live requests become drops; a response arriving now is consumed here.
      fetch_pc     <= redirect_pc;
      head_pc      <= redirect_pc;
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      q_count      <= '0;
      inflight     <= '0;
      drop_cnt     <= drop_cnt + inflight - CW'(rsp_drop || rsp_live);
      protocol_err <= protocol_err || rsp_err;
    end else begin
      if (issue) fetch_pc <= fetch_pc + STEP;
      if (pop) begin
        head_pc <= head_pc + STEP;
        rd_ptr  <= rd_ptr + AW'(1);
      end
      if (push) wr_ptr <= wr_ptr + AW'(1);
      q_count      <= q_count + CW'(push) - CW'(pop);
      inflight     <= inflight + CW'(issue) - CW'(rsp_live);
      drop_cnt     <= drop_cnt - CW'(rsp_drop);
      protocol_err <= protocol_err || rsp_err;
    end
  end

  // Queue storage carries no reset; validity is tracked by q_count alone.
  always_ff @(posedge clk) begin
    if (push) q_mem[wr_ptr] <= imem_rsp_data;
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Testbench for fetch_unit: directed scenarios plus randomized traffic checked against
// a program-order model of issued addresses and delivered instructions.
module tb_fetch_unit;
  localparam int          XLEN = 32, ILEN = 32, DEPTH = 4, PC_STEP = 4;
  localparam logic [31:0] RESET_PC = 32'h0;

  logic            clk = 1'b0, reset = 1'b1;
  logic            imem_req_valid, imem_req_ready = 1'b0;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_rsp_valid = 1'b0;
  logic [ILEN-1:0] imem_rsp_data = '0;
  logic            redirect_valid = 1'b0;
  logic [XLEN-1:0] redirect_pc = '0;
  logic            out_valid, out_ready = 1'b0;
  logic [ILEN-1:0] out_instr;
  logic [XLEN-1:0] out_pc, out_pc_next, fetch_pc;
  logic            protocol_err;

  fetch_unit #(.XLEN(XLEN), .ILEN(ILEN), .RESET_PC(RESET_PC), .PC_STEP(PC_STEP), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr), .imem_req_ready(imem_req_ready),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_pc(out_pc), .out_pc_next(out_pc_next), .fetch_pc(fetch_pc), .protocol_err(protocol_err)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  int cyc, first_acc, first_vld;
  logic [31:0] memq[$], acc_log[$], pop_log[$];
  logic [31:0] exp_req, exp_out, prev_addr;
  logic        exp_perr, prev_stall;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hA000_0000;
  endfunction

  // Reset every model structure together with the DUT; memory squashes its own pending responses.
  task automatic hold_reset();
    reset = 1'b1; imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    redirect_valid = 1'b0; redirect_pc = '0; out_ready = 1'b0;
    memq.delete(); acc_log.delete(); pop_log.delete();
    exp_req = RESET_PC; exp_out = RESET_PC; exp_perr = 1'b0; prev_stall = 1'b0;
    first_acc = -1; first_vld = -1; cyc = 0;
    repeat (2) @(negedge clk);
  endtask

  task automatic do_reset();
    hold_reset();
    reset = 1'b0;
  endtask

  // One clock cycle: drive at the falling edge, observe 1 time unit later, then advance.
  task automatic cycle(input logic rdy, input logic ordy, input logic redir, input logic [31:0] rpc,
                       input logic rsp_en, input logic spur);
    imem_req_ready = rdy; out_ready = ordy; redirect_valid = redir; redirect_pc = rpc;
    if (spur) begin imem_rsp_valid = 1'b1; imem_rsp_data = 32'hDEAD_BEEF; end
    else if (rsp_en && memq.size() > 0) begin imem_rsp_valid = 1'b1; imem_rsp_data = mem_word(memq[0]); end
    else begin imem_rsp_valid = 1'b0; imem_rsp_data = $urandom; end
    #1;
    if (prev_stall && !redir) begin
      checks++;
      if (imem_req_valid !== 1'b1 || imem_req_addr !== prev_addr) begin
        failures++; $display("FAIL req_hold: valid=%b addr=%h expected valid=1 addr=%h", imem_req_valid, imem_req_addr, prev_addr);
      end
    end
    if (redir) begin
      checks++;
      if (imem_req_valid !== 1'b0 || out_valid !== 1'b0) begin
        failures++; $display("FAIL redirect_quiet: req_valid=%b out_valid=%b expected 0/0", imem_req_valid, out_valid);
      end
    end
    checks++;
    if (protocol_err !== exp_perr) begin
      failures++; $display("FAIL protocol_err: got %b expected %b", protocol_err, exp_perr);
    end
    if (imem_req_valid === 1'b1 && rdy) begin
      checks++;
      if (imem_req_addr !== exp_req) begin
        failures++; $display("FAIL req_addr: got %h expected %h", imem_req_addr, exp_req);
      end
      memq.push_back(imem_req_addr); acc_log.push_back(imem_req_addr);
      exp_req = exp_req + 32'(PC_STEP);
      if (first_acc < 0) first_acc = cyc;
    end
    if (imem_rsp_valid && !spur) void'(memq.pop_front());
    if (out_valid === 1'b1 && first_vld < 0) first_vld = cyc;
    if (out_valid === 1'b1 && ordy) begin
      checks += 3;
      if (out_pc !== exp_out) begin failures++; $display("FAIL out_pc: got %h expected %h", out_pc, exp_out); end
      if (out_instr !== mem_word(exp_out)) begin failures++; $display("FAIL out_instr: got %h expected %h", out_instr, mem_word(exp_out)); end
      if (out_pc_next !== exp_out + 32'(PC_STEP)) begin failures++; $display("FAIL out_pc_next: got %h expected %h", out_pc_next, exp_out + 32'(PC_STEP)); end
      pop_log.push_back(out_pc);
      exp_out = exp_out + 32'(PC_STEP);
    end
    if (spur) exp_perr = 1'b1;
    if (redir) begin exp_out = rpc; exp_req = rpc; end
    prev_stall = imem_req_valid && !rdy && !redir;
    prev_addr  = imem_req_addr;
    @(posedge clk); @(negedge clk); cyc++;
  endtask

  task automatic test_reset();
    hold_reset();
    #1;
    checks++;
    if (imem_req_valid !== 1'b0 || out_valid !== 1'b0 || out_pc !== RESET_PC || out_pc_next !== RESET_PC + 32'(PC_STEP) ||
        out_instr !== '0 || fetch_pc !== RESET_PC || protocol_err !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: req_valid=%b out_valid=%b out_pc=%h next=%h instr=%h fetch_pc=%h perr=%b expected 0 0 %h %h 0 %h 0",
               imem_req_valid, out_valid, out_pc, out_pc_next, out_instr, fetch_pc, protocol_err,
               RESET_PC, RESET_PC + 32'(PC_STEP), RESET_PC);
    end
    @(negedge clk); reset = 1'b0;
  endtask

  task automatic test_stream();
    do_reset();
    repeat (12) cycle(1, 1, 0, 0, 1, 0);
    checks++;
    if (first_vld !== first_acc + 2) begin failures++; $display("FAIL stream_latency: out_valid at %0d expected %0d", first_vld, first_acc + 2); end
    checks++;
    if (pop_log.size() != 10) begin failures++; $display("FAIL stream_throughput: pops %0d expected 10", pop_log.size()); end
  endtask

  task automatic test_backpressure();
    do_reset();
    repeat (8) cycle(1, 0, 0, 0, 1, 0);
    checks++;
    if (acc_log.size() != 4 || imem_req_valid !== 1'b0) begin
      failures++; $display("FAIL bp_credit: accepts %0d req_valid=%b expected 4 and 0", acc_log.size(), imem_req_valid);
    end
    repeat (2) cycle(1, 1, 0, 0, 1, 0);
    checks++;
    if (acc_log[$] !== 32'h10) begin failures++; $display("FAIL bp_resume: last addr %h expected 00000010", acc_log[$]); end
    repeat (6) cycle(1, 1, 0, 0, 1, 0);
    checks++;
    if (pop_log.size() < 4 || pop_log[3] !== 32'hC) begin failures++; $display("FAIL bp_drain: pops %0d expected >=4 ending 0000000c", pop_log.size()); end
  endtask

  task automatic test_redirect_inflight();
    int asz, psz;
    do_reset();
    repeat (4) cycle(1, 1, 0, 0, 1, 0);
    repeat (2) cycle(1, 1, 0, 0, 0, 0);
    checks++;
    if (acc_log.size() != 6 || acc_log[$] !== 32'h14) begin failures++; $display("FAIL redir_setup: accepts %0d expected 6 ending 00000014", acc_log.size()); end
    cycle(1, 1, 1, 32'h100, 0, 0);
    asz = acc_log.size(); psz = pop_log.size();
    repeat (12) cycle(1, 1, 0, 0, 1, 0);
    checks++;
    if (acc_log.size() <= asz || acc_log[asz] !== 32'h100) begin failures++; $display("FAIL redir_req: first addr after redirect wrong, expected 00000100"); end
    checks++;
    if (pop_log.size() <= psz || pop_log[psz] !== 32'h100) begin failures++; $display("FAIL redir_pop: first out_pc after redirect wrong, expected 00000100"); end
  endtask

  task automatic test_redirect_pop();
    int psz;
    do_reset();
    repeat (3) cycle(1, 0, 0, 0, 1, 0);
    checks++;
    if (out_valid !== 1'b1) begin failures++; $display("FAIL rp_setup: out_valid=%b expected 1", out_valid); end
    psz = pop_log.size();
    cycle(1, 1, 1, 32'h200, 1, 0);
    checks++;
    if (pop_log.size() != psz) begin failures++; $display("FAIL rp_nopop: pops %0d expected %0d", pop_log.size(), psz); end
    repeat (6) cycle(1, 1, 0, 0, 1, 0);
    checks++;
    if (pop_log.size() <= psz || pop_log[psz] !== 32'h200) begin failures++; $display("FAIL rp_target: first pop after redirect wrong, expected 00000200"); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    repeat (4) cycle(1, 0, 0, 0, 1, 0);
    checks++;
    if (out_valid !== 1'b1) begin failures++; $display("FAIL rm_setup: out_valid=%b expected 1", out_valid); end
    reset = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || imem_req_valid !== 1'b0) begin
      failures++; $display("FAIL rm_async: out_valid=%b req_valid=%b expected 0/0", out_valid, imem_req_valid);
    end
    @(negedge clk);
    do_reset();
    cycle(1, 1, 0, 0, 1, 0);
    checks++;
    if (acc_log.size() != 1 || acc_log[0] !== RESET_PC) begin failures++; $display("FAIL rm_restart: first addr wrong, expected %h", RESET_PC); end
  endtask

  task automatic test_protocol_err();
    do_reset();
    cycle(0, 1, 0, 0, 1, 1);
    #1;
    checks++;
    if (protocol_err !== 1'b1 || out_valid !== 1'b0) begin
      failures++; $display("FAIL perr_set: perr=%b out_valid=%b expected 1/0", protocol_err, out_valid);
    end
    repeat (10) cycle(1, 1, 0, 0, 1, 0);
    checks++;
    if (pop_log.size() < 6 || protocol_err !== 1'b1) begin
      failures++; $display("FAIL perr_continue: pops %0d perr=%b expected >=6 and 1", pop_log.size(), protocol_err);
    end
  endtask

  task automatic test_random();
    logic [31:0] rpc;
    logic        redir;
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      redir = ($urandom_range(0, 24) == 0);
      rpc   = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 + 32'($urandom_range(0, 3)) * 4 : ($urandom & 32'hFFFF_FFFC);
      cycle($urandom_range(0, 2) != 0, $urandom_range(0, 3) != 0, redir, rpc, $urandom_range(0, 3) != 0, 1'b0);
    end
    checks++;
    if (pop_log.size() < 300) begin failures++; $display("FAIL rand_progress: pops %0d expected >=300", pop_log.size()); end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_inflight();
    test_redirect_pop();
    test_reset_mid();
    test_protocol_err();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Parametrised instruction-fetch stage, successor to the single-cycle Fetch block. It issues PC-sequential requests to an instruction memory over a valid/ready request channel with in-order responses. Returned words are buffered in a DEPTH-entry instruction queue and presented to decode over a valid/ready handshake, with PC and next-PC attached. Supports branch/jump redirect with queue flush and discard of in-flight responses.

Parameters:
XLEN, 32, PC/address width
ILEN, 32, instruction word width
RESET_PC, 32'h0000_0000, fetch PC after reset
PC_STEP, 4, PC increment per instruction
DEPTH, 4, instruction queue entries; also max outstanding requests (power of 2, >=2)

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  asynchronous, active-high reset
imem_req_valid  out  1  fetch request valid
imem_req_addr  out  XLEN  fetch address (= fetch_pc)
imem_req_ready  in  1  memory accepts request
imem_rsp_valid  in  1  response valid, in request order, >=1 cycle after acceptance
imem_rsp_data  in  ILEN  instruction word
redirect_valid  in  1  redirect request (branch/jump/exception)
redirect_pc  in  XLEN  redirect target
out_valid  out  1  instruction available to decode
out_ready  in  1  decode accepts instruction
out_instr  out  ILEN  queue head instruction
out_pc  out  XLEN  PC of out_instr
out_pc_next  out  XLEN  out_pc + PC_STEP
fetch_pc  out  XLEN  address of next request to issue
protocol_err  out  1  sticky: response with nothing outstanding

Behaviour:
- Reset (async, immediate): fetch_pc=RESET_PC, head_pc=RESET_PC, queue empty, inflight=0, drop_cnt=0, protocol_err=0; so imem_req_valid=0 during reset, out_valid=0, out_pc=RESET_PC, out_pc_next=RESET_PC+PC_STEP, out_instr=0. Reset mid-operation discards all queue/in-flight state; responses to pre-reset requests are the memory's responsibility to squash.
- Credit: issue permitted when q_count + inflight + drop_cnt < DEPTH. imem_req_valid = credit && !redirect_valid && !reset.
- Issue: on imem_req_valid && imem_req_ready: inflight+1, fetch_pc += PC_STEP (wraps modulo 2^XLEN). Once asserted, valid/addr hold stable until accepted except in a redirect cycle (withdrawn, addr changes next cycle).
- Response: if drop_cnt>0: drop_cnt-1, data discarded. Else if inflight>0: push data to queue tail, inflight-1. Else: ignore, set protocol_err (cleared only by reset).
- Output: out_valid = (q_count>0) && !redirect_valid. Pop on out_valid && out_ready: head_pc += PC_STEP. Latency: request accepted cycle N, response cycle N+1 -> out_valid cycle N+2. Sustained throughput 1 instr/cycle with out_ready=1 and 1-cycle memory.
- Simultaneous push and pop: both occur, q_count unchanged. Credit guarantees no push to a full queue; overflow is impossible by construction.
- Redirect (highest priority): in cycle with redirect_valid: no issue, no pop; at edge: queue flushed, drop_cnt += inflight (plus any response discarded that cycle handled consistently: response arriving in redirect cycle is discarded and counted off), inflight=0, fetch_pc=head_pc=redirect_pc. Issue resumes next cycle at redirect_pc.
- Back-to-back redirects: last one wins; drop accounting accumulates.
- out_pc = head_pc; out_pc_next = head_pc + PC_STEP (modulo 2^XLEN).

Test Plan:
- Reset release, imem_req_ready=1, 1-cycle memory returning data=addr|32'hA000_0000, out_ready=1 -> imem_req_addr 0,4,8,...; out_valid from 2nd cycle after first accept; out_pc 0,4,8 with out_instr A000_0000, A000_0004, A000_0008; out_pc_next = out_pc+4.
- out_ready=0 -> exactly 4 requests (0x0..0xC) accepted then imem_req_valid=0; raise out_ready -> pops 0x0,0x4,0x8,0xC in order, requests resume at 0x10.
- Two requests in flight (0x10, 0x14), redirect_valid with redirect_pc=0x100 -> both responses dropped, queue empty, next request addr 0x100, first out_pc=0x100, out_pc_next=0x104.
- redirect_valid in same cycle as queue non-empty and out_ready=1 -> out_valid=0 that cycle, no pop, next out_pc=redirect_pc.
- reset pulsed mid-stream with 3 queued entries -> out_valid=0, imem_req_valid=0 immediately; after release first request addr=RESET_PC.
- imem_rsp_valid=1 with inflight=0, drop_cnt=0 -> protocol_err=1 and stays 1, q_count unchanged, normal fetch continues.
